// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX boundary bundle: decode-side fields and flow controls in, registered
// EX-side copies, IF/ID stall request and bubble counter out.
interface id_ex_hazard_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  flush;
  logic                  hold;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [DATA_W-1:0]     id_rd1;
  logic [DATA_W-1:0]     id_rd2;
  logic [DATA_W-1:0]     id_imm;
  logic [DATA_W-1:0]     id_pc;
  logic                  id_regWrite;
  logic                  id_memRead;
  logic                  id_memWrite;
  logic                  id_memToReg;
  logic                  id_ALUSrcB;
  logic [3:0]            id_alu_ctrl;

  logic                  id_ex_valid;
  logic [REG_ADDR_W-1:0] id_ex_rs1;
  logic [REG_ADDR_W-1:0] id_ex_rs2;
  logic                  id_ex_rs1_used;
  logic                  id_ex_rs2_used;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic [DATA_W-1:0]     id_ex_rd1;
  logic [DATA_W-1:0]     id_ex_rd2;
  logic [DATA_W-1:0]     id_ex_imm;
  logic [DATA_W-1:0]     id_ex_pc;
  logic                  id_ex_regWrite;
  logic                  id_ex_memRead;
  logic                  id_ex_memWrite;
  logic                  id_ex_memToReg;
  logic                  id_ex_ALUSrcB;
  logic [3:0]            id_ex_alu_ctrl;
  logic                  stall_if_id;
  logic [CNT_W-1:0]      bubble_count;

  modport master (
    output flush, hold, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rd1, id_rd2, id_imm, id_pc, id_regWrite, id_memRead, id_memWrite,
           id_memToReg, id_ALUSrcB, id_alu_ctrl,
    input  id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rs1_used, id_ex_rs2_used, id_ex_rd,
           id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc, id_ex_regWrite, id_ex_memRead,
           id_ex_memWrite, id_ex_memToReg, id_ex_ALUSrcB, id_ex_alu_ctrl,
           stall_if_id, bubble_count
  );

  modport slave (
    input  flush, hold, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rd1, id_rd2, id_imm, id_pc, id_regWrite, id_memRead, id_memWrite,
           id_memToReg, id_ALUSrcB, id_alu_ctrl,
    output id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rs1_used, id_ex_rs2_used, id_ex_rd,
           id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc, id_ex_regWrite, id_ex_memRead,
           id_ex_memWrite, id_ex_memToReg, id_ex_ALUSrcB, id_ex_alu_ctrl,
           stall_if_id, bubble_count
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection. A load in EX whose
// destination is read by the instruction in ID gets one bubble; the ID
// instruction then advances and picks the value up from MEM/WB forwarding.
module id_ex_hazard_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input logic               clk,
  input logic               rst_n,
  id_ex_hazard_reg_if.slave bus
);
  typedef enum logic {RUN, BUBBLE} state_t;

  localparam logic [CNT_W-1:0]      CNT_MAX = '1;
  localparam logic [DATA_W-1:0]     ZERO_D  = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_R  = '0;

  state_t state;
  logic   hazard;
  logic   take_bubble;
  logic   zero_next;
  logic   ctl_en;

  // Load-use detection and stall request; BUBBLE masks the hazard term.
  always_comb begin
    hazard = bus.id_valid & bus.id_ex_valid & bus.id_ex_memRead & (bus.id_ex_rd != ZERO_R) &
             ((bus.id_rs1_used & (bus.id_rs1 == bus.id_ex_rd)) |
              (bus.id_rs2_used & (bus.id_rs2 == bus.id_ex_rd)));
    take_bubble     = hazard & (state == RUN);
    bus.stall_if_id = (take_bubble & ~bus.flush) | (bus.hold & ~bus.flush);
    zero_next       = bus.flush | take_bubble;
    ctl_en          = bus.id_valid & ~zero_next;
  end

  // Pipeline register: flush/bubble loads zeros, hold freezes, else load ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.id_ex_valid    <= 1'b0;
      bus.id_ex_rs1      <= ZERO_R;
      bus.id_ex_rs2      <= ZERO_R;
      bus.id_ex_rs1_used <= 1'b0;
      bus.id_ex_rs2_used <= 1'b0;
      bus.id_ex_rd       <= ZERO_R;
      bus.id_ex_rd1      <= ZERO_D;
      bus.id_ex_rd2      <= ZERO_D;
      bus.id_ex_imm      <= ZERO_D;
      bus.id_ex_pc       <= ZERO_D;
      bus.id_ex_regWrite <= 1'b0;
      bus.id_ex_memRead  <= 1'b0;
      bus.id_ex_memWrite <= 1'b0;
      bus.id_ex_memToReg <= 1'b0;
      bus.id_ex_ALUSrcB  <= 1'b0;
      bus.id_ex_alu_ctrl <= 4'd0;
    end else if (bus.flush || !bus.hold) begin
      bus.id_ex_valid    <= bus.id_valid & ~zero_next;
      bus.id_ex_rs1      <= zero_next ? ZERO_R : bus.id_rs1;
      bus.id_ex_rs2      <= zero_next ? ZERO_R : bus.id_rs2;
      bus.id_ex_rs1_used <= bus.id_rs1_used & ~zero_next;
      bus.id_ex_rs2_used <= bus.id_rs2_used & ~zero_next;
      bus.id_ex_rd       <= zero_next ? ZERO_R : bus.id_rd;
      bus.id_ex_rd1      <= zero_next ? ZERO_D : bus.id_rd1;
      bus.id_ex_rd2      <= zero_next ? ZERO_D : bus.id_rd2;
      bus.id_ex_imm      <= zero_next ? ZERO_D : bus.id_imm;
      bus.id_ex_pc       <= zero_next ? ZERO_D : bus.id_pc;
      bus.id_ex_regWrite <= bus.id_regWrite & ctl_en;
      bus.id_ex_memRead  <= bus.id_memRead & ctl_en;
      bus.id_ex_memWrite <= bus.id_memWrite & ctl_en;
      bus.id_ex_memToReg <= bus.id_memToReg & ctl_en;
      bus.id_ex_ALUSrcB  <= bus.id_ALUSrcB & ctl_en;
      bus.id_ex_alu_ctrl <= bus.id_alu_ctrl & {4{ctl_en}};
    end
  end

  // Bubble FSM and saturating bubble counter; flush and hold both suppress counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      bus.bubble_count <= '0;
    end else if (bus.flush) begin
      state <= RUN;
    end else if (!bus.hold) begin
      if (take_bubble) begin
        state <= BUBBLE;
        if (bus.bubble_count != CNT_MAX) bus.bubble_count <= bus.bubble_count + 1'b1;
      end else begin
        state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Randomized and directed stimulus for the ID/EX hazard register, scored by a
// queue-based monitor against a behavioural model of the pipeline stage.
module tb_id_ex_hazard_reg;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  // Narrow counter so saturation is reachable in a short run.
  localparam int unsigned CW = 4;
  localparam int unsigned CNT_SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_hazard_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) ifc ();

  id_ex_hazard_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic          rw;
    logic          mr;
    logic          mw;
    logic          m2r;
    logic          asb;
    logic [3:0]    alu;
  } ex_t;

  typedef struct packed {
    logic          stall;
    ex_t           ex;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t        q[$];
  ex_t         m_ex;
  bit          m_bub;
  int unsigned m_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic ex_t dut_ex();
    ex_t r;
    r.valid = ifc.id_ex_valid;    r.rs1 = ifc.id_ex_rs1;      r.rs2 = ifc.id_ex_rs2;
    r.u1    = ifc.id_ex_rs1_used; r.u2  = ifc.id_ex_rs2_used; r.rd  = ifc.id_ex_rd;
    r.rd1   = ifc.id_ex_rd1;      r.rd2 = ifc.id_ex_rd2;      r.imm = ifc.id_ex_imm;
    r.pc    = ifc.id_ex_pc;       r.rw  = ifc.id_ex_regWrite; r.mr  = ifc.id_ex_memRead;
    r.mw    = ifc.id_ex_memWrite; r.m2r = ifc.id_ex_memToReg; r.asb = ifc.id_ex_ALUSrcB;
    r.alu   = ifc.id_ex_alu_ctrl;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive_in(input ex_t in, input logic fl, input logic hd);
    ifc.flush       = fl;      ifc.hold        = hd;
    ifc.id_valid    = in.valid; ifc.id_rs1     = in.rs1;  ifc.id_rs2      = in.rs2;
    ifc.id_rs1_used = in.u1;   ifc.id_rs2_used = in.u2;   ifc.id_rd       = in.rd;
    ifc.id_rd1      = in.rd1;  ifc.id_rd2      = in.rd2;  ifc.id_imm      = in.imm;
    ifc.id_pc       = in.pc;   ifc.id_regWrite = in.rw;   ifc.id_memRead  = in.mr;
    ifc.id_memWrite = in.mw;   ifc.id_memToReg = in.m2r;  ifc.id_ALUSrcB  = in.asb;
    ifc.id_alu_ctrl = in.alu;
  endtask

  // Build an instruction with chosen register usage and random payload.
  function automatic ex_t mk(input logic v, input int r1, input int r2, input logic u1,
                             input logic u2, input int rd, input logic mr, input logic rw);
    ex_t i;
    i.valid = v; i.rs1 = AW'(r1); i.rs2 = AW'(r2); i.u1 = u1; i.u2 = u2; i.rd = AW'(rd);
    i.rd1 = $urandom; i.rd2 = $urandom; i.imm = $urandom; i.pc = $urandom;
    i.rw = rw; i.mr = mr; i.mw = 1'($urandom); i.m2r = mr; i.asb = 1'($urandom);
    i.alu = 4'($urandom);
    return i;
  endfunction

  function automatic ex_t rnd_instr();
    ex_t i;
    i = mk(($urandom_range(0, 7) != 0), $urandom_range(0, 31), $urandom_range(0, 31),
           1'($urandom), 1'($urandom), $urandom_range(0, 31), ($urandom_range(0, 2) == 0),
           1'($urandom));
    i.m2r = 1'($urandom);
    if ($urandom_range(0, 1) == 0) i.rs1 = m_ex.rd;
    else if ($urandom_range(0, 2) == 0) i.rs2 = m_ex.rd;
    return i;
  endfunction

  // One ID cycle: drive inputs, predict stall and the next EX-side contents.
  task automatic issue(input ex_t in, input logic fl, input logic hd);
    logic hz, st;
    exp_t e;
    @(negedge clk);
    drive_in(in, fl, hd);
    hz = in.valid && m_ex.valid && m_ex.mr && (m_ex.rd != 0) &&
         ((in.u1 && in.rs1 == m_ex.rd) || (in.u2 && in.rs2 == m_ex.rd));
    st = (hz && !fl && !m_bub) || (hd && !fl);
    if (fl) begin
      m_ex  = '0;
      m_bub = 1'b0;
    end else if (!hd) begin
      if (hz && !m_bub) begin
        m_ex  = '0;
        m_bub = 1'b1;
        if (m_cnt < CNT_SAT) m_cnt++;
      end else begin
        m_ex = in;
        if (!in.valid) begin
          m_ex.rw = 0; m_ex.mr = 0; m_ex.mw = 0; m_ex.m2r = 0; m_ex.asb = 0; m_ex.alu = 0;
        end
        m_bub = 1'b0;
      end
    end
    #1;
    e.stall = st;
    e.ex    = m_ex;
    e.cnt   = CW'(m_cnt);
    q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    cmp({tag, "_ex"}, 256'(dut_ex()), 256'(0));
    cmp({tag, "_cnt"}, 256'(ifc.bubble_count), 256'(0));
    cmp({tag, "_stall"}, 256'(ifc.stall_if_id), 256'(ifc.hold & ~ifc.flush));
  endtask

  // Monitor: stall is checked mid-cycle, registered fields just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q[0];
        cmp("stall_if_id", 256'(ifc.stall_if_id), 256'(e.stall));
        @(posedge clk);
        #1;
        e = q.pop_front();
        cmp("id_ex_fields", 256'(dut_ex()), 256'(e.ex));
        cmp("bubble_count", 256'(ifc.bubble_count), 256'(e.cnt));
      end
    end
  end

  initial begin
    ex_t lw5, add5, lw0, add0, addi;
    m_ex  = '0;
    m_bub = 1'b0;
    m_cnt = 0;
    rst_n = 1'b0;
    drive_in('0, 1'b0, 1'b0);
    #12;
    check_reset_state("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    lw5  = mk(1, 2, 0, 1, 0, 5, 1, 1);
    add5 = mk(1, 5, 7, 1, 1, 6, 0, 1);
    lw0  = mk(1, 3, 0, 1, 0, 0, 1, 1);
    add0 = mk(1, 0, 1, 1, 1, 6, 0, 1);
    addi = mk(1, 8, 5, 1, 0, 6, 0, 1);

    // lw x5; add x6,x5,x7: one bubble then add advances
    issue(lw5, 0, 0); issue(add5, 0, 0); issue(add5, 0, 0); issue(addi, 0, 0);
    // lw x0 producer never stalls
    issue(lw0, 0, 0); issue(add0, 0, 0);
    // unused rs2 matching the load destination
    issue(lw5, 0, 0); issue(addi, 0, 0);
    // flush coincident with hazard
    issue(lw5, 0, 0); issue(add5, 1, 0); issue(addi, 0, 0);
    // flush with hold
    issue(lw5, 0, 0); issue(add5, 1, 1);
    // drive the counter into saturation
    repeat (CNT_SAT + 2) begin
      issue(lw5, 0, 0); issue(add5, 0, 0); issue(add5, 0, 0);
    end
    // hold across a pending hazard, then exactly one bubble
    issue(lw5, 0, 0);
    repeat (3) issue(add5, 0, 1);
    issue(add5, 0, 0); issue(add5, 0, 0); issue(addi, 0, 0);

    // asynchronous reset mid-cycle with live state
    issue(lw5, 0, 0); issue(add5, 0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_mid");
    m_ex  = '0;
    m_bub = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++)
      issue(rnd_instr(), ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0));

    repeat (4) @(posedge clk);
    #2;
    cmp("scoreboard_drained", 256'(q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
